ram_port_arbiter: RTL and testbench

Shares the dual-port 32-bit RAM between two requesters, m0 and m1. Port A (write) and port B (read) are arbitrated independently, so one master can write while the other reads in the same cycle. Each port has round-robin fairness and an optional lock for multi-cycle ownership, such as a read-modify-write sequence in the Fibonacci sequencer. The block sits between the sequencing FSMs and the RAM instance and drives the RAM address, data and write-enable pins directly.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter_fsm.sv | 89 ++++++++
 rtl/ram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Master indices
  localparam int M0 = 0;
  localparam int M1 = 1;

  // Port ownership state
  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM arbiter: one instance per master.
interface ram_port_arbiter_if;
  import ram_arb_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_port_arbiter_fsm.sv
// Owner FSM for one RAM port: round-robin between two qualified requests,
// with lock-based multi-cycle ownership. Ownership taken on this port is
// released by an unlocked grant to the owner on either port, so a locked
// read followed by an unlocking write frees the read port as well.
module port_owner_fsm
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,       // requests qualified for this port
  input  logic [1:0] lock,      // lock bit of each master
  input  logic [1:0] rel,       // master granted anywhere with lock = 0
  input  logic       last_gnt,  // current last-grant bit (1 = m1 last)
  output logic [1:0] gnt,       // one-hot grant on this port
  output logic       last_nxt   // updated last-grant bit
);

  owner_e state_r;
  owner_e state_s;

  // Owner state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FREE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant selection, last-grant update and next-state logic
  always_comb begin
    gnt      = 2'b00;
    state_s  = state_r;
    last_nxt = last_gnt;

    case (state_r)
      FREE: begin
        if (req[M0] && req[M1]) begin
          if (last_gnt) begin
            gnt = 2'b01;
          end else begin
            gnt = 2'b10;
          end
        end else begin
          gnt = req;
        end
      end
      OWN0:    gnt = {1'b0, req[M0]};
      OWN1:    gnt = {req[M1], 1'b0};
      default: gnt = 2'b00;
    endcase

    if (gnt[M0]) begin
      last_nxt = 1'b0;
    end else if (gnt[M1]) begin
      last_nxt = 1'b1;
    end else begin
      last_nxt = last_gnt;
    end

    case (state_r)
      FREE: begin
        if (gnt[M0] && lock[M0]) begin
          state_s = OWN0;
        end else if (gnt[M1] && lock[M1]) begin
          state_s = OWN1;
        end else begin
          state_s = FREE;
        end
      end
      OWN0: begin
        if (rel[M0]) begin
          state_s = FREE;
        end else begin
          state_s = OWN0;
        end
      end
      OWN1: begin
        if (rel[M1]) begin
          state_s = FREE;
        end else begin
          state_s = OWN1;
        end
      end
      default: state_s = FREE;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM write port A and read port B between two masters,
// returns read data one cycle after grant, and bypasses same-cycle
// same-address writes into the read return.
module ram_port_arbiter
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave m0,
  ram_port_arbiter_if.slave m1,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  logic [1:0]        wr_req_s;
  logic [1:0]        rd_req_s;
  logic [1:0]        lock_s;
  logic [1:0]        wr_gnt_s;
  logic [1:0]        rd_gnt_s;
  logic [1:0]        mst_gnt_s;
  logic [1:0]        rel_s;
  logic              wr_last_r;
  logic              rd_last_r;
  logic              wr_last_s;
  logic              rd_last_s;
  logic              rd_valid_r;
  logic              rd_tag_r;
  logic              byp_hit_r;
  logic [DATA_W-1:0] byp_data_r;
  logic [DATA_W-1:0] rd_data_s;

  assign wr_req_s  = {m1.req & m1.we,  m0.req & m0.we};
  assign rd_req_s  = {m1.req & ~m1.we, m0.req & ~m0.we};
  assign lock_s    = {m1.lock, m0.lock};
  assign mst_gnt_s = wr_gnt_s | rd_gnt_s;
  assign rel_s     = mst_gnt_s & ~lock_s;

  assign m0.gnt = mst_gnt_s[M0];
  assign m1.gnt = mst_gnt_s[M1];

  port_owner_fsm u_wr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (wr_req_s),
    .lock     (lock_s),
    .rel      (rel_s),
    .last_gnt (wr_last_r),
    .gnt      (wr_gnt_s),
    .last_nxt (wr_last_s)
  );

  port_owner_fsm u_rd_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rd_req_s),
    .lock     (lock_s),
    .rel      (rel_s),
    .last_gnt (rd_last_r),
    .gnt      (rd_gnt_s),
    .last_nxt (rd_last_s)
  );

  // Port A mux: winner's address/data, zeros when idle
  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = {ADDR_W{1'b0}};
    ram_dina  = {DATA_W{1'b0}};
    if (wr_gnt_s[M0]) begin
      ram_wea   = 1'b1;
      ram_addra = m0.addr;
      ram_dina  = m0.wdata;
    end else if (wr_gnt_s[M1]) begin
      ram_wea   = 1'b1;
      ram_addra = m1.addr;
      ram_dina  = m1.wdata;
    end else begin
      ram_wea   = 1'b0;
      ram_addra = {ADDR_W{1'b0}};
      ram_dina  = {DATA_W{1'b0}};
    end
  end

  // Port B mux: winner's address, zero when idle
  always_comb begin
    ram_addrb = {ADDR_W{1'b0}};
    if (rd_gnt_s[M0]) begin
      ram_addrb = m0.addr;
    end else if (rd_gnt_s[M1]) begin
      ram_addrb = m1.addr;
    end else begin
      ram_addrb = {ADDR_W{1'b0}};
    end
  end

  // Last-grant bits; reset to "m1 last" so m0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_r <= 1'b1;
      rd_last_r <= 1'b1;
    end else begin
      wr_last_r <= wr_last_s;
      rd_last_r <= rd_last_s;
    end
  end

  // Read return tracking and same-cycle write bypass capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_tag_r   <= 1'b0;
      byp_hit_r  <= 1'b0;
      byp_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= |rd_gnt_s;
      rd_tag_r   <= rd_gnt_s[M1];
      if ((|rd_gnt_s) && ram_wea && (ram_addra == ram_addrb)) begin
        byp_hit_r  <= 1'b1;
        byp_data_r <= ram_dina;
      end else begin
        byp_hit_r  <= 1'b0;
        byp_data_r <= {DATA_W{1'b0}};
      end
    end
  end

  // Returned read data: bypassed write data wins over the RAM output
  always_comb begin
    rd_data_s = ram_doutb;
    if (byp_hit_r) begin
      rd_data_s = byp_data_r;
    end else begin
      rd_data_s = ram_doutb;
    end
  end

  assign m0.rvalid = rd_valid_r & ~rd_tag_r;
  assign m1.rvalid = rd_valid_r & rd_tag_r;
  assign m0.rdata  = m0.rvalid ? rd_data_s : {DATA_W{1'b0}};
  assign m1.rdata  = m1.rvalid ? rd_data_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural dual-port RAM.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_doutb;
  logic [DATA_W-1:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;

  ram_port_arbiter_if m0_bus ();
  ram_port_arbiter_if m1_bus ();

  ram_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write on A, registered read on B (read-old on collision)
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic lock,
                     input logic [4:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.lock = lock;
      m0_bus.addr = addr; m0_bus.wdata = wdata;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.lock = lock;
      m1_bus.addr = addr; m1_bus.wdata = wdata;
    end
  endtask

  task automatic idle(input int m);
    drv(m, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0);
    idle(1);
    tick();
    tick();
    settle();
    // Reset state
    chk("rst_m0_gnt", m0_bus.gnt, 32'd0);
    chk("rst_m1_gnt", m1_bus.gnt, 32'd0);
    chk("rst_wea", ram_wea, 32'd0);
    chk("rst_addra", ram_addra, 32'd0);
    chk("rst_dina", ram_dina, 32'd0);
    chk("rst_addrb", ram_addrb, 32'd0);
    chk("rst_m0_rvalid", m0_bus.rvalid, 32'd0);
    chk("rst_m1_rvalid", m1_bus.rvalid, 32'd0);
    rst_n = 1'b1;
    tick();

    // Preload RAM[3] = 0x15 through m1
    drv(1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h15);
    settle();
    chk("pre_m1_gnt", m1_bus.gnt, 32'd1);
    tick();
    idle(1);

    // Single read of addr 3 by m0
    drv(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd0);
    settle();
    chk("rd_m0_gnt", m0_bus.gnt, 32'd1);
    chk("rd_m1_gnt", m1_bus.gnt, 32'd0);
    chk("rd_addrb", ram_addrb, 32'd3);
    chk("rd_wea", ram_wea, 32'd0);
    tick();
    idle(0);
    settle();
    chk("rd_m0_rvalid", m0_bus.rvalid, 32'd1);
    chk("rd_m0_rdata", m0_bus.rdata, 32'h15);
    chk("rd_m1_rvalid", m1_bus.rvalid, 32'd0);
    tick();
    settle();
    chk("rd_m0_rvalid_end", m0_bus.rvalid, 32'd0);

    // Write contention: m0 first, m1 next cycle
    drv(0, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA);
    drv(1, 1'b1, 1'b1, 1'b0, 5'd2, 32'hB);
    settle();
    chk("wc1_m0_gnt", m0_bus.gnt, 32'd1);
    chk("wc1_m1_gnt", m1_bus.gnt, 32'd0);
    chk("wc1_wea", ram_wea, 32'd1);
    chk("wc1_addra", ram_addra, 32'd1);
    chk("wc1_dina", ram_dina, 32'hA);
    tick();
    idle(0);
    settle();
    chk("wc2_m1_gnt", m1_bus.gnt, 32'd1);
    chk("wc2_wea", ram_wea, 32'd1);
    chk("wc2_addra", ram_addra, 32'd2);
    chk("wc2_dina", ram_dina, 32'hB);
    tick();
    idle(1);
    settle();
    chk("wc3_wea", ram_wea, 32'd0);
    chk("wc3_addra", ram_addra, 32'd0);

    // Parallel ports with same-address bypass
    drv(0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h22);
    drv(1, 1'b1, 1'b0, 1'b0, 5'd4, 32'd0);
    settle();
    chk("par_m0_gnt", m0_bus.gnt, 32'd1);
    chk("par_m1_gnt", m1_bus.gnt, 32'd1);
    chk("par_addra", ram_addra, 32'd4);
    chk("par_addrb", ram_addrb, 32'd4);
    tick();
    idle(0);
    drv(1, 1'b1, 1'b0, 1'b0, 5'd1, 32'd0);
    settle();
    chk("byp_m1_rvalid", m1_bus.rvalid, 32'd1);
    chk("byp_m1_rdata", m1_bus.rdata, 32'h22);
    chk("byp_m0_rvalid", m0_bus.rvalid, 32'd0);
    chk("raw_m1_gnt", m1_bus.gnt, 32'd1);
    tick();
    idle(1);
    settle();
    chk("raw_m1_rdata", m1_bus.rdata, 32'hA);
    chk("raw_m0_rvalid", m0_bus.rvalid, 32'd0);
    tick();

    // Lock: m0 locked read, then unlocking write; m1 reads throughout
    drv(0, 1'b1, 1'b0, 1'b1, 5'd5, 32'd0);
    drv(1, 1'b1, 1'b0, 1'b0, 5'd6, 32'd0);
    settle();
    chk("lk_a_m0_gnt", m0_bus.gnt, 32'd1);
    chk("lk_a_m1_gnt", m1_bus.gnt, 32'd0);
    tick();
    drv(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h55);
    settle();
    chk("lk_b_m0_gnt", m0_bus.gnt, 32'd1);
    chk("lk_b_m1_gnt", m1_bus.gnt, 32'd0);
    chk("lk_b_wea", ram_wea, 32'd1);
    tick();
    drv(0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd0);
    settle();
    chk("lk_c_m1_gnt", m1_bus.gnt, 32'd1);
    chk("lk_c_m0_gnt", m0_bus.gnt, 32'd0);
    chk("lk_c_addrb", ram_addrb, 32'd6);
    tick();
    idle(1);
    settle();
    chk("lk_d_m0_gnt", m0_bus.gnt, 32'd1);
    chk("lk_d_m1_rvalid", m1_bus.rvalid, 32'd1);
    tick();
    idle(0);
    tick();

    // Reset in the cycle after a locked read grant
    drv(0, 1'b1, 1'b0, 1'b1, 5'd3, 32'd0);
    settle();
    chk("rr_m0_gnt", m0_bus.gnt, 32'd1);
    tick();
    idle(0);
    rst_n = 1'b0;
    settle();
    chk("rr_m0_rvalid_async", m0_bus.rvalid, 32'd0);
    tick();
    settle();
    chk("rr_m0_rvalid_held", m0_bus.rvalid, 32'd0);
    rst_n = 1'b1;
    tick();
    drv(1, 1'b1, 1'b0, 1'b0, 5'd2, 32'd0);
    settle();
    chk("rr_m1_rd_gnt_free", m1_bus.gnt, 32'd1);
    tick();
    idle(1);
    drv(0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h1);
    drv(1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h2);
    settle();
    chk("rr_wc_m0_gnt", m0_bus.gnt, 32'd1);
    chk("rr_wc_m1_gnt", m1_bus.gnt, 32'd0);
    tick();
    idle(0);
    idle(1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
